// File: rtl/fetch_queue_pkg.sv
// Shared widths and prediction layout for the instruction fetch queue.
// Entry packing is {pc, ir, bpred}, with the PC in the most significant bits.
package fetch_queue_pkg;

    localparam int INST_W      = 32;
    localparam int BPRED_W     = 33;
    localparam int BP_TAKEN    = 32;
    localparam int BP_TARGET_W = 32;

    typedef struct packed {
        logic                   pred_taken;
        logic [BP_TARGET_W-1:0] target;
    } bpred_t;

    function automatic int entry_width(input int pc_w, input int bp_w);
        return pc_w + INST_W + bp_w;
    endfunction

    function automatic logic pred_taken(input logic [BPRED_W-1:0] bp);
        return bp[BP_TAKEN];
    endfunction

endpackage

// File: rtl/fq_storage.sv
// Entry register array for the fetch queue.
// It has one synchronous write port and one combinational read port, and is cleared by the active-low reset.
module fq_storage
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = entry_width(32, BPRED_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the imem read port and decode.
// It buffers {pc, ir, bpred} in order and discards stale responses after a branch-miss flush.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int BP_W  = 33
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [PC_W-1:0]          enq_pc,
    input  logic [INST_W-1:0]        enq_ir,
    input  logic [BP_W-1:0]          enq_bpred,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [PC_W-1:0]          deq_pc,
    output logic [PC_W-1:0]          deq_pc4,
    output logic [INST_W-1:0]        deq_ir,
    output logic [BP_W-1:0]          deq_bpred,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = entry_width(PC_W, BP_W);

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   occupancy;
    logic               drop_next;
    logic               enq_fire;
    logic               deq_fire;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    assign enq_ready = (occupancy != CNT_W'(DEPTH));
    assign deq_valid = (occupancy != '0);
    assign count     = occupancy;

    // drop_next kills the single imem response that was already in flight when the flush arrived.
    assign enq_fire = enq_valid && enq_ready && !flush && !drop_next;
    assign deq_fire = deq_valid && deq_ready && !flush;

    assign wr_entry = {enq_pc, enq_ir, enq_bpred};

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            drop_next <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            drop_next <= 1'b1;
        end else begin
            drop_next <= 1'b0;
            if (enq_fire) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    fq_storage #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_storage (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (enq_fire),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (rd_entry)
    );

    assign {deq_pc, deq_ir, deq_bpred} = rd_entry;
    assign deq_pc4 = deq_pc + PC_W'(4);

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a queue-based reference model tracks the expected contents,
// and a negedge monitor compares the DUT head and status against it.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int BP_W  = 33;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            enq_valid;
    logic            enq_ready;
    logic [31:0]     enq_pc;
    logic [31:0]     enq_ir;
    logic [32:0]     enq_bpred;
    logic            deq_valid;
    logic            deq_ready;
    logic [31:0]     deq_pc;
    logic [31:0]     deq_pc4;
    logic [31:0]     deq_ir;
    logic [32:0]     deq_bpred;
    logic [2:0]      count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [32:0] bp;
    } ent_t;

    ent_t mq[$];
    bit   model_drop = 1'b0;
    bit   started    = 1'b0;
    int   errors     = 0;
    int   checks     = 0;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W),
        .BP_W  (BP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_pc    (enq_pc),
        .enq_ir    (enq_ir),
        .enq_bpred (enq_bpred),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_pc    (deq_pc),
        .deq_pc4   (deq_pc4),
        .deq_ir    (deq_ir),
        .deq_bpred (deq_bpred),
        .count     (count)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then settle just after the capturing edge.
    task automatic applyStimulus(input logic ev, input logic [31:0] pc, input logic [31:0] ir,
                                 input logic [32:0] bp, input logic dr, input logic fl);
        enq_valid = ev;
        enq_pc    = pc;
        enq_ir    = ir;
        enq_bpred = bp;
        deq_ready = dr;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a FIFO of expected entries, updated from the inputs seen at each edge.
    always @(posedge clk) begin
        if (!rst) begin
            mq.delete();
            model_drop = 1'b0;
        end else if (flush) begin
            mq.delete();
            model_drop = 1'b1;
        end else begin
            bit   do_enq;
            bit   do_deq;
            ent_t e;
            do_enq = enq_valid && (mq.size() < DEPTH) && !model_drop;
            do_deq = deq_ready && (mq.size() > 0);
            if (do_deq) void'(mq.pop_front());
            if (do_enq) begin
                e.pc = enq_pc;
                e.ir = enq_ir;
                e.bp = enq_bpred;
                mq.push_back(e);
            end
            model_drop = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            checkOutput("count", 64'(count), 64'(mq.size()));
            checkOutput("deq_valid", 64'(deq_valid), 64'(mq.size() != 0));
            checkOutput("enq_ready", 64'(enq_ready), 64'(mq.size() != DEPTH));
            if (deq_valid && mq.size() > 0) begin
                logic [31:0] p4;
                p4 = mq[0].pc + 32'd4;
                checkOutput("deq_pc", 64'(deq_pc), 64'(mq[0].pc));
                checkOutput("deq_pc4", 64'(deq_pc4), 64'(p4));
                checkOutput("deq_ir", 64'(deq_ir), 64'(mq[0].ir));
                checkOutput("deq_bpred", 64'(deq_bpred), 64'(mq[0].bp));
            end
        end
    end

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        enq_valid = 1'b0;
        enq_pc = '0;
        enq_ir = '0;
        enq_bpred = '0;
        deq_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        started = 1'b1;
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_enq_ready", 64'(enq_ready), 64'd1);
        checkOutput("rst_deq_valid", 64'(deq_valid), 64'd0);
        checkOutput("rst_deq_pc", 64'(deq_pc), 64'd0);
        checkOutput("rst_deq_ir", 64'(deq_ir), 64'd0);
        checkOutput("rst_deq_bpred", 64'(deq_bpred), 64'd0);
        rst = 1'b1;

        // In-order basic enqueue then dequeue
        for (int i = 0; i < 3; i++) applyStimulus(1, 32'(i * 4), 32'h20080001 + 32'(i), '0, 0, 0);
        checkOutput("seq_count3", 64'(count), 64'd3);
        checkOutput("seq_head_pc", 64'(deq_pc), 64'h0);
        checkOutput("seq_head_pc4", 64'(deq_pc4), 64'h4);
        for (int i = 0; i < 3; i++) applyStimulus(0, '0, '0, '0, 1, 0);
        checkOutput("seq_drained", 64'(count), 64'd0);
        checkOutput("seq_drained_valid", 64'(deq_valid), 64'd0);

        // Full queue, then stream through the wrap point
        for (int i = 0; i < 4; i++) applyStimulus(1, 32'h1000 + 32'(i * 4), 32'hA000 + 32'(i), '0, 0, 0);
        checkOutput("full_enq_ready", 64'(enq_ready), 64'd0);
        applyStimulus(1, 32'h1010, 32'hA004, '0, 1, 0);
        checkOutput("full_after_deq_count", 64'(count), 64'd3);
        checkOutput("full_after_deq_ready", 64'(enq_ready), 64'd1);
        for (int i = 0; i < 10; i++) applyStimulus(1, 32'h2000 + 32'(i * 4), 32'hB000 + 32'(i), '0, 1, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, '0, '0, '0, 1, 0);
        checkOutput("wrap_drained", 64'(count), 64'd0);

        // Flush with concurrent enq/deq, stale response dropped
        applyStimulus(1, 32'h3000, 32'hC000, '0, 0, 0);
        applyStimulus(1, 32'h3004, 32'hC001, '0, 0, 0);
        applyStimulus(1, 32'h3008, 32'hC002, '0, 1, 1);
        checkOutput("flush_count", 64'(count), 64'd0);
        checkOutput("flush_deq_valid", 64'(deq_valid), 64'd0);
        applyStimulus(1, 32'h40, 32'hC003, '0, 0, 0);
        checkOutput("flush_drop", 64'(count), 64'd0);
        applyStimulus(1, 32'h100, 32'hC004, '0, 0, 0);
        checkOutput("flush_accept_count", 64'(count), 64'd1);
        checkOutput("flush_accept_pc", 64'(deq_pc), 64'h100);
        applyStimulus(0, '0, '0, '0, 1, 0);

        // Steady state at one entry with a taken prediction
        applyStimulus(1, 32'h500, 32'hD000, 33'h1_00000020, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 32'h504 + 32'(i * 4), 32'hD001 + 32'(i), 33'h1_00000020, 1, 0);
            checkOutput("steady_count", 64'(count), 64'd1);
            checkOutput("steady_bpred", 64'(deq_bpred), 64'h1_00000020);
        end
        applyStimulus(0, '0, '0, '0, 1, 0);

        // Reset mid-stream overrides flush and clears drop_next
        for (int i = 0; i < 3; i++) applyStimulus(1, 32'h600 + 32'(i * 4), 32'hE000 + 32'(i), 33'h1_0000FFFF, 0, 0);
        rst = 1'b0;
        applyStimulus(1, 32'h700, 32'hE100, '0, 1, 1);
        checkOutput("mid_rst_count", 64'(count), 64'd0);
        checkOutput("mid_rst_enq_ready", 64'(enq_ready), 64'd1);
        checkOutput("mid_rst_deq_pc", 64'(deq_pc), 64'd0);
        checkOutput("mid_rst_deq_ir", 64'(deq_ir), 64'd0);
        checkOutput("mid_rst_deq_bpred", 64'(deq_bpred), 64'd0);
        rst = 1'b1;
        applyStimulus(1, 32'h200, 32'hE200, '0, 0, 0);
        checkOutput("post_rst_accept", 64'(count), 64'd1);
        checkOutput("post_rst_pc", 64'(deq_pc), 64'h200);
        applyStimulus(0, '0, '0, '0, 1, 0);

        // PC+4 wraps modulo 2^32
        applyStimulus(1, 32'hFFFFFFFC, 32'hF000, '0, 0, 0);
        checkOutput("pc4_wrap", 64'(deq_pc4), 64'h0);
        applyStimulus(0, '0, '0, '0, 1, 0);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) != 0);
            applyStimulus($urandom_range(0, 3) != 0, $urandom & 32'hFFFFFFFC, $urandom,
                          {1'($urandom_range(0, 1)), 32'($urandom)},
                          $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        end
        rst = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus(0, '0, '0, '0, 1, 0);
        checkOutput("final_empty", 64'(count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the instruction memory read port and the ID stage of the 5-stage core. Captures each fetched word with its PC and BTB prediction, buffers up to DEPTH entries, and presents them in order to decode with a valid/ready handshake. On a branch miss signalled from WB it discards all buffered entries and the one stale imem response still in flight.

## Interface

Parameters:
- DEPTH, 4: entries; power of two, ≥2
- PC_W, 32: PC width
- BP_W, 33: prediction width, {pred_taken, target_pc}

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset; synchronous, active-low (state clears on a posedge where rst==0)
- flush  in  1  branch miss from WB; kills queue contents
- enq_valid  in  1  imem response valid this cycle
- enq_ready  out  1  queue can accept an entry this cycle
- enq_pc  in  PC_W  PC of the fetched word
- enq_ir  in  32  fetched instruction
- enq_bpred  in  BP_W  BTB prediction for enq_pc
- deq_valid  out  1  head entry valid
- deq_ready  in  1  ID consumes head this cycle
- deq_pc  out  PC_W  head PC
- deq_pc4  out  PC_W  head PC + 4
- deq_ir  out  32  head instruction
- deq_bpred  out  BP_W  head prediction
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation

- Circular buffer: wr_ptr, rd_ptr of $clog2(DEPTH) bits (wrap modulo DEPTH); count tracks occupancy 0..DEPTH.
- Enqueue fires when enq_valid && enq_ready && !flush && !drop_next: writes {pc, ir, bpred} at wr_ptr, wr_ptr+1.
- Dequeue fires when deq_valid && deq_ready && !flush: rd_ptr+1.
- count next = count + enq_fire − deq_fire; simultaneous enq and deq leaves count unchanged.
- enq_ready = (count != DEPTH); independent of deq_ready (no combinational ready path through the queue). Full queue with deq_ready=1 still shows enq_ready=0.
- deq_valid = (count != 0); deq_* read combinationally from the entry at rd_ptr; deq_pc4 = deq_pc + 4, modulo 2^PC_W.
- Flush (priority over enq and deq): count←0, wr_ptr←0, rd_ptr←0, drop_next←1. Storage contents left as-is.
- drop_next: set by flush, cleared the following cycle. While set, an arriving enq_valid is discarded (it is the imem response to a pre-flush PC, imem latency is 1). Flush on consecutive cycles keeps drop_next set.
- Reset (rst==0): count, pointers, drop_next ← 0; deq_valid=0, enq_ready=1, count=0. deq_pc/deq_ir/deq_bpred read storage, which also resets to 0, so all deq data outputs are 0 after reset. Reset overrides flush.

## Timing

- Enqueue-to-dequeue latency: 1 cycle (entry written at edge N is visible on deq_* after edge N, consumable at edge N+1). No same-cycle bypass.
- Sustained throughput 1 entry/cycle when 0<count<DEPTH.
- Flush at edge N: deq_valid=0 after N; enq_valid in cycle N+1 ignored; first accepted entry at edge N+2, on deq_* after it.
- enq_ready, deq_valid, count are pure functions of registered state.

## Structure

- Shared package: INST_W=32, BP_W=33 prediction layout (bit 32 = pred_taken, [31:0] = target), and the packed entry width PC_W+INST_W+BP_W.
- One sub-module natural: fq_storage, DEPTH×entry register array, one synchronous write port, one combinational read port, synchronous active-low clear. Pointer/count/flush logic stays in fetch_queue.

## Test plan

- Reset then enqueue pc=0x0,0x4,0x8 (ir=0x20080001.., bpred=0) with deq_ready=0 -> count=3, deq_pc=0x0, deq_pc4=0x4; then deq_ready=1 three cycles -> pc 0x0,0x4,0x8 in order, count=0, deq_valid=0.
- Fill DEPTH=4 entries -> enq_ready=0; hold enq_valid=1, deq_ready=1 -> one dequeue, enq_ready=1 next cycle, no entry lost or duplicated; wrap past index 3 preserves order over 10 entries.
- Queue with 2 entries, flush=1 together with enq_valid and deq_ready -> count=0, deq_valid=0; next cycle enq_valid pc=0x40 dropped; following cycle pc=0x100 accepted, deq_pc=0x100.
- Steady enq+deq each cycle at count=1 -> count stays 1, one instruction out per cycle, bpred=0x1_00000020 passes through unchanged.
- rst=0 asserted mid-stream with count=3 and flush=1 -> count=0, enq_ready=1, deq_* all 0, drop_next clear (enq on first cycle after reset accepted).
- deq_pc=0xFFFFFFFC -> deq_pc4=0x00000000.
